// File: rtl/rx_cmd_frame_decoder_pkg.sv
// Shared constants, FSM state type and helpers for the UART command frame decoder.
package rx_cmd_pkg;
  localparam logic [7:0] START_BYTE  = 8'h3A;
  localparam logic [7:0] OPC_IMG     = 8'h49;
  localparam logic [7:0] OPC_RES     = 8'h52;
  localparam logic [7:0] OPC_OUT     = 8'h4F;
  localparam logic [7:0] OPC_HRES    = 8'h48;
  localparam logic [7:0] OPC_VRES    = 8'h56;
  localparam logic [7:0] OPC_RST     = 8'h58;
  localparam logic [7:0] LEGACY_BASE = 8'h61;
  localparam logic [7:0] LEGACY_LAST = 8'h78;
  localparam logic [7:0] LEGACY_RST  = 8'h79;
  localparam logic [7:0] LEGACY_NUL  = 8'h00;

  typedef enum logic [2:0] {ST_IDLE, ST_OPC, ST_CHAN, ST_ARG, ST_CSUM} state_t;

  // One enable per configuration field; legacy commands write several at once.
  typedef struct packed {
    logic img;
    logic res;
    logic out;
    logic hres;
    logic vres;
  } field_mask_t;

  function automatic int timeout_cnt_w(input int timeout);
    return $clog2(timeout + 1);
  endfunction
endpackage

// File: rtl/rx_cmd_frame_decoder_if.sv
// Byte stream from the UART receiver plus the decoder's command status strobes.
interface rx_cmd_frame_decoder_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       cmd_ack;
  logic       cmd_err;
  logic       busy;

  modport master (output rx_data, rx_valid, input cmd_ack, cmd_err, busy);
  modport slave  (input rx_data, rx_valid, output cmd_ack, cmd_err, busy);
endinterface

// File: rtl/rx_cmd_frame_decoder_ch_cfg_regs.sv
// One channel's shadow/active configuration, blanking-gated commit and reset pulse.
module ch_cfg_regs
  import rx_cmd_pkg::*;
#(
  parameter int SEL_W     = 2,
  parameter int RES_W     = 8,
  parameter int RST_PULSE = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             pix_en,
  input  field_mask_t      wr_mask,
  input  logic [SEL_W-1:0] wr_img,
  input  logic [SEL_W-1:0] wr_res,
  input  logic             wr_out,
  input  logic [RES_W-1:0] wr_hres,
  input  logic [RES_W-1:0] wr_vres,
  input  logic             rst_cmd,
  output logic [SEL_W-1:0] img_sel,
  output logic [SEL_W-1:0] res_sel,
  output logic             out_sel,
  output logic [RES_W-1:0] hres,
  output logic [RES_W-1:0] vres,
  output logic             ch_reset
);
  localparam int RC_W = $clog2(RST_PULSE + 1);

  logic [SEL_W-1:0] sh_img_reg, sh_res_reg, img_reg, res_reg;
  logic             sh_out_reg, out_reg, pending_reg;
  logic [RES_W-1:0] sh_hres_reg, sh_vres_reg, hres_reg, vres_reg;
  logic [RC_W-1:0]  rst_cnt_reg;

  // Later assignments win: a write overrides a same-cycle commit's pending clear,
  // and a channel reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sh_img_reg  <= '0;
      sh_res_reg  <= '0;
      sh_out_reg  <= 1'b0;
      sh_hres_reg <= '0;
      sh_vres_reg <= '0;
      img_reg     <= '0;
      res_reg     <= '0;
      out_reg     <= 1'b0;
      hres_reg    <= '0;
      vres_reg    <= '0;
      pending_reg <= 1'b0;
      rst_cnt_reg <= '0;
    end else begin
      if (rst_cnt_reg != '0)
        rst_cnt_reg <= rst_cnt_reg - RC_W'(1);
      if (pending_reg && !pix_en) begin
        img_reg     <= sh_img_reg;
        res_reg     <= sh_res_reg;
        out_reg     <= sh_out_reg;
        hres_reg    <= sh_hres_reg;
        vres_reg    <= sh_vres_reg;
        pending_reg <= 1'b0;
      end
      if (wr_mask != '0)
        pending_reg <= 1'b1;
      if (wr_mask.img)  sh_img_reg  <= wr_img;
      if (wr_mask.res)  sh_res_reg  <= wr_res;
      if (wr_mask.out)  sh_out_reg  <= wr_out;
      if (wr_mask.hres) sh_hres_reg <= wr_hres;
      if (wr_mask.vres) sh_vres_reg <= wr_vres;
      if (rst_cmd) begin
        sh_img_reg  <= '0;
        sh_res_reg  <= '0;
        sh_out_reg  <= 1'b0;
        sh_hres_reg <= '0;
        sh_vres_reg <= '0;
        img_reg     <= '0;
        res_reg     <= '0;
        out_reg     <= 1'b0;
        hres_reg    <= '0;
        vres_reg    <= '0;
        pending_reg <= 1'b0;
        rst_cnt_reg <= RC_W'(RST_PULSE);
      end
    end
  end

  assign img_sel  = img_reg;
  assign res_sel  = res_reg;
  assign out_sel  = out_reg;
  assign hres     = hres_reg;
  assign vres     = vres_reg;
  assign ch_reset = (rst_cnt_reg != '0);
endmodule

// File: rtl/rx_cmd_frame_decoder.sv
// Framed/legacy UART command parser driving per-channel shadow/active video configuration.
module rx_cmd_frame_decoder
  import rx_cmd_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int SEL_W     = 2,
  parameter int RES_W     = 8,
  parameter int TIMEOUT   = 100000,
  parameter int RST_PULSE = 16,
  parameter int LEGACY_EN = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  rx_cmd_frame_decoder_if.slave   bus,
  input  logic [NUM_CH-1:0]       pix_en,
  output logic [NUM_CH*SEL_W-1:0] img_sel,
  output logic [NUM_CH*SEL_W-1:0] res_sel,
  output logic [NUM_CH-1:0]       out_sel,
  output logic [NUM_CH-1:0]       ch_reset,
  output logic [NUM_CH*RES_W-1:0] hres,
  output logic [NUM_CH*RES_W-1:0] vres
);
  localparam int         TO_W     = timeout_cnt_w(TIMEOUT);
  localparam int         CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] NUM_CH_B = 8'(NUM_CH);

  state_t           state_reg, state_next;
  logic [7:0]       opc_reg, opc_next, ch_reg, ch_next, arg_reg, arg_next;
  logic [TO_W-1:0]  idle_cnt_reg, idle_cnt_next;
  logic             ack_reg, ack_next, err_reg, err_next;

  field_mask_t      wr_mask;
  logic [CH_W-1:0]  wr_ch;
  logic [SEL_W-1:0] wr_img, wr_res;
  logic             wr_out, rst_cmd;
  logic [RES_W-1:0] wr_hres, wr_vres;

  logic [7:0] leg_idx, leg_img, leg_res;
  logic       frame_ok;

  assign leg_idx  = bus.rx_data - LEGACY_BASE;
  assign leg_img  = (leg_idx >> 3) + 8'd1;
  assign leg_res  = {6'd0, leg_idx[1:0]};
  assign frame_ok = (bus.rx_data == (opc_reg ^ ch_reg ^ arg_reg)) && (ch_reg < NUM_CH_B) &&
                    (opc_reg inside {OPC_IMG, OPC_RES, OPC_OUT, OPC_HRES, OPC_VRES, OPC_RST});

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      opc_reg      <= '0;
      ch_reg       <= '0;
      arg_reg      <= '0;
      idle_cnt_reg <= '0;
      ack_reg      <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      opc_reg      <= opc_next;
      ch_reg       <= ch_next;
      arg_reg      <= arg_next;
      idle_cnt_reg <= idle_cnt_next;
      ack_reg      <= ack_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    opc_next      = opc_reg;
    ch_next       = ch_reg;
    arg_next      = arg_reg;
    idle_cnt_next = idle_cnt_reg;
    ack_next      = 1'b0;
    err_next      = 1'b0;
    wr_mask       = '0;
    wr_ch         = ch_reg[CH_W-1:0];
    wr_img        = arg_reg[SEL_W-1:0];
    wr_res        = arg_reg[SEL_W-1:0];
    wr_out        = arg_reg[0];
    wr_hres       = RES_W'(arg_reg);
    wr_vres       = RES_W'(arg_reg);
    rst_cmd       = 1'b0;
    if (bus.rx_valid) begin
      idle_cnt_next = '0;
      if (state_reg == ST_IDLE) begin
        if (bus.rx_data == START_BYTE) begin
          state_next = ST_OPC;
        end else if (LEGACY_EN != 0) begin
          if (bus.rx_data >= LEGACY_BASE && bus.rx_data <= LEGACY_LAST) begin
            wr_ch    = '0;
            wr_mask  = '{img: 1'b1, res: 1'b1, out: 1'b1, hres: 1'b0, vres: 1'b0};
            wr_img   = SEL_W'(leg_img);
            wr_res   = SEL_W'(leg_res);
            wr_out   = leg_idx[2];
            ack_next = 1'b1;
          end else if (bus.rx_data == LEGACY_RST || bus.rx_data == LEGACY_NUL) begin
            wr_ch    = '0;
            rst_cmd  = 1'b1;
            ack_next = 1'b1;
          end
        end
      end else if (bus.rx_data == START_BYTE) begin
        // Unexpected start byte: drop the partial frame and treat it as a new one.
        err_next   = 1'b1;
        state_next = ST_OPC;
      end else begin
        case (state_reg)
          ST_OPC:  begin opc_next = bus.rx_data; state_next = ST_CHAN; end
          ST_CHAN: begin ch_next  = bus.rx_data; state_next = ST_ARG;  end
          ST_ARG:  begin arg_next = bus.rx_data; state_next = ST_CSUM; end
          ST_CSUM: begin
            state_next = ST_IDLE;
            if (frame_ok) begin
              ack_next = 1'b1;
              case (opc_reg)
                OPC_IMG:  wr_mask.img  = 1'b1;
                OPC_RES:  wr_mask.res  = 1'b1;
                OPC_OUT:  wr_mask.out  = 1'b1;
                OPC_HRES: wr_mask.hres = 1'b1;
                OPC_VRES: wr_mask.vres = 1'b1;
                default:  rst_cmd      = 1'b1;
              endcase
            end else begin
              err_next = 1'b1;
            end
          end
          default: state_next = ST_IDLE;
        endcase
      end
    end else if (state_reg != ST_IDLE) begin
      if (idle_cnt_reg == TO_W'(TIMEOUT)) begin
        state_next    = ST_IDLE;
        err_next      = 1'b1;
        idle_cnt_next = '0;
      end else begin
        idle_cnt_next = idle_cnt_reg + TO_W'(1);
      end
    end
  end

  assign bus.cmd_ack = ack_reg;
  assign bus.cmd_err = err_reg;
  assign bus.busy    = (state_reg != ST_IDLE);

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_ch
    logic        sel;
    field_mask_t mask;
    assign sel  = (wr_ch == CH_W'(gi));
    assign mask = sel ? wr_mask : '0;

    ch_cfg_regs #(
      .SEL_W     (SEL_W),
      .RES_W     (RES_W),
      .RST_PULSE (RST_PULSE)
    ) u_regs (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .pix_en   (pix_en[gi]),
      .wr_mask  (mask),
      .wr_img   (wr_img),
      .wr_res   (wr_res),
      .wr_out   (wr_out),
      .wr_hres  (wr_hres),
      .wr_vres  (wr_vres),
      .rst_cmd  (rst_cmd && sel),
      .img_sel  (img_sel[gi*SEL_W +: SEL_W]),
      .res_sel  (res_sel[gi*SEL_W +: SEL_W]),
      .out_sel  (out_sel[gi]),
      .hres     (hres[gi*RES_W +: RES_W]),
      .vres     (vres[gi*RES_W +: RES_W]),
      .ch_reset (ch_reset[gi])
    );
  end
endmodule

// File: tb/tb_rx_cmd_frame_decoder.sv
// Randomized bench for rx_cmd_frame_decoder against a byte-level behavioural model.
module tb_rx_cmd_frame_decoder;
  localparam int NUM_CH    = 2;
  localparam int SEL_W     = 2;
  localparam int RES_W     = 8;
  localparam int TIMEOUT   = 40;
  localparam int RST_PULSE = 16;
  localparam int LEGACY_EN = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NUM_CH-1:0]       pix_en = '0;
  logic [NUM_CH*SEL_W-1:0] img_sel, res_sel;
  logic [NUM_CH-1:0]       out_sel, ch_reset;
  logic [NUM_CH*RES_W-1:0] hres, vres;

  always #5 clk = ~clk;

  rx_cmd_frame_decoder_if bus_if();

  rx_cmd_frame_decoder #(
    .NUM_CH(NUM_CH), .SEL_W(SEL_W), .RES_W(RES_W),
    .TIMEOUT(TIMEOUT), .RST_PULSE(RST_PULSE), .LEGACY_EN(LEGACY_EN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus_if.slave), .pix_en(pix_en),
    .img_sel(img_sel), .res_sel(res_sel), .out_sel(out_sel),
    .ch_reset(ch_reset), .hres(hres), .vres(vres)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- behavioural model ----------------
  // m_pos = number of frame bytes collected so far (0 = waiting for a start byte).
  // Fields per channel: 0 img, 1 res, 2 out, 3 hres, 4 vres.
  int         m_pos = 0, m_idle = 0;
  logic [7:0] m_frm [5];
  int         sh  [NUM_CH][5];
  int         act [NUM_CH][5];
  bit         pend[NUM_CH];
  int         rcnt[NUM_CH];
  bit         exp_ack = 0, exp_err = 0, model_live = 0;
  int         wch, idx;
  bit         wm[5];
  int         wv[5];
  bit         do_rst;
  logic [7:0] o, c8, a8;

  always @(posedge clk) begin
    if (rst) begin
      m_pos = 0; m_idle = 0; exp_ack = 0; exp_err = 0; model_live = 1;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int f = 0; f < 5; f++) begin sh[c][f] = 0; act[c][f] = 0; end
        pend[c] = 0; rcnt[c] = 0;
      end
    end else begin
      exp_ack = 0; exp_err = 0; do_rst = 0; wch = 0;
      for (int f = 0; f < 5; f++) begin wm[f] = 0; wv[f] = 0; end
      if (bus_if.rx_valid) begin
        m_idle = 0;
        if (m_pos == 0) begin
          if (bus_if.rx_data == 8'h3A) m_pos = 1;
          else if (LEGACY_EN != 0 && bus_if.rx_data >= 8'h61 && bus_if.rx_data <= 8'h78) begin
            idx = int'(bus_if.rx_data) - 97;
            wm[0] = 1; wm[1] = 1; wm[2] = 1;
            wv[0] = (idx / 8 + 1) % (1 << SEL_W);
            wv[1] = (idx % 4) % (1 << SEL_W);
            wv[2] = (idx / 4) % 2;
            exp_ack = 1;
          end else if (LEGACY_EN != 0 && (bus_if.rx_data == 8'h79 || bus_if.rx_data == 8'h00)) begin
            do_rst = 1; exp_ack = 1;
          end
        end else if (bus_if.rx_data == 8'h3A) begin
          exp_err = 1; m_pos = 1;
        end else begin
          m_frm[m_pos] = bus_if.rx_data;
          m_pos++;
          if (m_pos == 5) begin
            m_pos = 0;
            o = m_frm[1]; c8 = m_frm[2]; a8 = m_frm[3];
            if (m_frm[4] == (o ^ c8 ^ a8) && int'(c8) < NUM_CH &&
                (o inside {8'h49, 8'h52, 8'h4F, 8'h48, 8'h56, 8'h58})) begin
              exp_ack = 1;
              wch = int'(c8);
              case (o)
                8'h49:   begin wm[0] = 1; wv[0] = int'(a8) % (1 << SEL_W); end
                8'h52:   begin wm[1] = 1; wv[1] = int'(a8) % (1 << SEL_W); end
                8'h4F:   begin wm[2] = 1; wv[2] = int'(a8) % 2; end
                8'h48:   begin wm[3] = 1; wv[3] = int'(a8) % (1 << RES_W); end
                8'h56:   begin wm[4] = 1; wv[4] = int'(a8) % (1 << RES_W); end
                default: do_rst = 1;
              endcase
            end else begin
              exp_err = 1;
            end
          end
        end
      end else if (m_pos != 0) begin
        if (m_idle == TIMEOUT) begin m_pos = 0; m_idle = 0; exp_err = 1; end
        else m_idle++;
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (rcnt[c] > 0) rcnt[c]--;
        if (pend[c] && !pix_en[c]) begin
          for (int f = 0; f < 5; f++) act[c][f] = sh[c][f];
          pend[c] = 0;
        end
        if (c == wch) begin
          for (int f = 0; f < 5; f++)
            if (wm[f]) begin sh[c][f] = wv[f]; pend[c] = 1; end
          if (do_rst) begin
            for (int f = 0; f < 5; f++) begin sh[c][f] = 0; act[c][f] = 0; end
            pend[c] = 0; rcnt[c] = RST_PULSE;
          end
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic cmp_all();
    logic [NUM_CH*SEL_W-1:0] e_img, e_res;
    logic [NUM_CH-1:0]       e_out, e_rst;
    logic [NUM_CH*RES_W-1:0] e_h, e_v;
    if (!model_live) return;
    for (int c = 0; c < NUM_CH; c++) begin
      e_img[c*SEL_W +: SEL_W] = SEL_W'(act[c][0]);
      e_res[c*SEL_W +: SEL_W] = SEL_W'(act[c][1]);
      e_out[c]                = 1'(act[c][2]);
      e_h[c*RES_W +: RES_W]   = RES_W'(act[c][3]);
      e_v[c*RES_W +: RES_W]   = RES_W'(act[c][4]);
      e_rst[c]                = (rcnt[c] != 0);
    end
    check("img_sel",  32'(img_sel),  32'(e_img));
    check("res_sel",  32'(res_sel),  32'(e_res));
    check("out_sel",  32'(out_sel),  32'(e_out));
    check("hres",     32'(hres),     32'(e_h));
    check("vres",     32'(vres),     32'(e_v));
    check("ch_reset", 32'(ch_reset), 32'(e_rst));
    check("cmd_ack",  32'(bus_if.cmd_ack), 32'(exp_ack));
    check("cmd_err",  32'(bus_if.cmd_err), 32'(exp_err));
    check("busy",     32'(bus_if.busy),    32'(m_pos != 0));
  endtask

  // ---------------- stimulus ----------------
  bit         rand_pix = 0;
  logic [7:0] tx_q[$];
  int         txn_no = 0;

  task automatic tick();
    @(negedge clk);
    cmp_all();
    if (rand_pix)
      for (int c = 0; c < NUM_CH; c++) pix_en[c] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_seq(input string tag, input bit rnd_gap);
    string s = "";
    int    gap;
    for (int i = 0; i < tx_q.size(); i++) begin
      gap = 0;
      if (rnd_gap && i != tx_q.size() - 1)
        gap = ($urandom_range(0, 15) == 0) ? int'($urandom_range(TIMEOUT - 1, TIMEOUT + 1))
                                           : int'($urandom_range(0, 2));
      s = {s, $sformatf(" %02h", tx_q[i])};
      send_byte(tx_q[i], gap);
    end
    txn_no++;
    $display("TXN %0d %s bytes:%s pix_en=%b", txn_no, tag, s, pix_en);
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] ch, input logic [7:0] arg,
                       input logic [7:0] cs);
    tx_q = '{8'h3A, op, ch, arg, cs};
    send_seq("frame", 0);
  endtask

  task automatic rand_txn();
    logic [7:0] opl[7] = '{8'h49, 8'h52, 8'h4F, 8'h48, 8'h56, 8'h58, 8'h51};
    logic [7:0] op, ch, arg, cs;
    int kind = int'($urandom_range(0, 9));
    op  = opl[$urandom_range(0, 5)];
    ch  = 8'($urandom_range(0, NUM_CH - 1));
    arg = 8'($urandom);
    cs  = op ^ ch ^ arg;
    tx_q = {};
    if (kind <= 4) begin
      tx_q = '{8'h3A, op, ch, arg, cs};
    end else if (kind == 5) begin
      case ($urandom_range(0, 2))
        0:       cs = cs ^ 8'($urandom_range(1, 255));
        1:       begin ch = 8'($urandom_range(NUM_CH, 7)); cs = op ^ ch ^ arg; end
        default: begin op = opl[6]; cs = op ^ ch ^ arg; end
      endcase
      tx_q = '{8'h3A, op, ch, arg, cs};
    end else if (kind <= 7) begin
      tx_q.push_back(($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(8'h5F, 8'h7B)));
    end else if (kind == 8) begin
      tx_q.push_back(8'h3A);
      repeat ($urandom_range(1, 3)) tx_q.push_back(8'($urandom_range(8'h40, 8'h59)));
      tx_q.push_back(8'h3A); tx_q.push_back(op); tx_q.push_back(ch);
      tx_q.push_back(arg);   tx_q.push_back(cs);
    end else begin
      tx_q.push_back(8'h3A);
      repeat ($urandom_range(0, 3)) tx_q.push_back(8'($urandom_range(8'h40, 8'h59)));
    end
    send_seq($sformatf("rand kind=%0d", kind), 1);
    if (kind == 9) repeat ($urandom_range(TIMEOUT - 1, TIMEOUT + 3)) tick();
    else repeat ($urandom_range(0, 3)) tick();
  endtask

  initial begin
    int n;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    check("reset_img",  32'(img_sel), 32'd0);

    // Write held off while channel 1 is in active video.
    pix_en = 2'b10;
    frame(8'h49, 8'h01, 8'h02, 8'h4A);
    check("img_ack", 32'(bus_if.cmd_ack), 32'd1);
    check("img_ch1_held", 32'(img_sel[1*SEL_W +: SEL_W]), 32'd0);
    repeat (3) tick();
    check("img_ch1_still_held", 32'(img_sel[1*SEL_W +: SEL_W]), 32'd0);
    pix_en = 2'b00;
    tick();
    check("img_ch1_commit", 32'(img_sel[1*SEL_W +: SEL_W]), 32'd2);

    // Rejected frames.
    frame(8'h52, 8'h00, 8'h03, 8'h50);
    check("bad_csum_err", 32'(bus_if.cmd_err), 32'd1);
    frame(8'h52, 8'h05, 8'h03, 8'h54);
    check("bad_ch_err", 32'(bus_if.cmd_err), 32'd1);
    tick();
    check("bad_res_unchanged", 32'(res_sel), 32'd0);

    // Legacy 'k' then 'y'.
    tx_q = '{8'h6B}; send_seq("legacy", 0);
    check("legacy_k_ack", 32'(bus_if.cmd_ack), 32'd1);
    tick();
    check("legacy_k_img", 32'(img_sel[0 +: SEL_W]), 32'd2);
    check("legacy_k_res", 32'(res_sel[0 +: SEL_W]), 32'd2);
    check("legacy_k_out", 32'(out_sel[0]), 32'd0);
    tx_q = '{8'h79}; send_seq("legacy", 0);
    check("legacy_y_cfg", 32'(img_sel[0 +: SEL_W]), 32'd0);
    n = 0;
    while (ch_reset[0] && n < 4 * RST_PULSE) begin n++; tick(); end
    check("rst_pulse_len", 32'(n), 32'(RST_PULSE));

    // Inter-byte timeout.
    tx_q = '{8'h3A, 8'h48, 8'h00}; send_seq("partial", 0);
    check("partial_busy", 32'(bus_if.busy), 32'd1);
    n = 0;
    while (!bus_if.cmd_err && n < TIMEOUT + 10) begin tick(); n++; end
    check("timeout_wait", 32'(n), 32'(TIMEOUT + 1));
    check("timeout_busy", 32'(bus_if.busy), 32'd0);
    frame(8'h56, 8'h00, 8'h07, 8'h51);
    check("after_timeout_ack", 32'(bus_if.cmd_ack), 32'd1);

    // Resync on an unexpected start byte.
    tx_q = '{8'h3A, 8'h4F, 8'h3A}; send_seq("resync", 0);
    check("resync_err", 32'(bus_if.cmd_err), 32'd1);
    tx_q = '{8'h4F, 8'h01, 8'h01, 8'h4F}; send_seq("resync_tail", 0);
    check("resync_ack", 32'(bus_if.cmd_ack), 32'd1);
    tick();
    check("resync_out_ch1", 32'(out_sel[1]), 32'd1);

    // New write lands on the same cycle an older pending write commits.
    pix_en = 2'b01;
    frame(8'h48, 8'h00, 8'h11, 8'h59);
    tx_q = '{8'h3A, 8'h48, 8'h00, 8'h50}; send_seq("hres_head", 0);
    pix_en = 2'b00;
    tx_q = '{8'h18}; send_seq("hres_csum", 0);
    tick();
    check("hres_final", 32'(hres[0 +: RES_W]), 32'h50);

    rand_pix = 1;
    repeat (400) rand_txn();
    rand_pix = 0;
    pix_en = '0;
    repeat (TIMEOUT + RST_PULSE + 5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
